// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: tile sequencer for the 2D MAC array (kernel load, settle gap, exec stream, drain).
// Read addresses are issued from next-state so they appear registered with the state; inst_w lags by one cycle.
module mac_array_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_bw  = 8,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [len_bw-1:0]  exec_len,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    output logic               sram_cen,
    output logic [addr_bw-1:0] sram_addr,
    output logic [1:0]         inst_w,
    output logic               mode_select,
    input  logic [col-1:0]     array_valid,
    output logic [len_bw-1:0]  out_cnt,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int tmax = 4 * (row + col) - 1;
    localparam int tw   = $clog2(tmax + 1);
    localparam int cw   = (tw > len_bw) ? tw : len_bw;

    typedef enum logic [2:0] {IDLE, LOAD, GAP, EXEC, DRAIN, FIN} state_t;

    state_t             state, nstate;
    logic [cw-1:0]      cnt, ncnt;
    logic [len_bw-1:0]  len_q;
    logic [addr_bw-1:0] wb_q, xb_q, naddr;
    logic               prev_v, accept, timeout, rd, inc;

    always_comb begin
        nstate  = state;
        ncnt    = cnt + cw'(1);
        timeout = 1'b0;
        accept  = (state == IDLE) && start && (exec_len != '0);
        case (state)
            IDLE: begin
                ncnt = '0;
                if (accept) nstate = LOAD;
            end
            LOAD: if (cnt == cw'(col - 1)) begin
                nstate = GAP;
                ncnt   = '0;
            end
            GAP: if (cnt == cw'(row - 1)) begin
                nstate = EXEC;
                ncnt   = '0;
            end
            EXEC: if (cnt == cw'(len_q) - cw'(1)) begin
                nstate = DRAIN;
                ncnt   = '0;
            end
            DRAIN: begin
                if (out_cnt == len_q) begin
                    nstate = FIN;
                    ncnt   = '0;
                end else if (cnt == cw'(tmax - 1)) begin
                    // the timer would reach tmax on this edge: give up on the tile
                    nstate  = IDLE;
                    timeout = 1'b1;
                    ncnt    = '0;
                end
            end
            default: begin
                nstate = IDLE;
                ncnt   = '0;
            end
        endcase
        rd    = (nstate == LOAD) || (nstate == EXEC);
        naddr = ((nstate == LOAD) ? ((state == IDLE) ? w_base : wb_q) : xb_q) + addr_bw'(ncnt);
        inc   = ((state == EXEC) || (state == DRAIN)) && array_valid[col-1] && !prev_v && (out_cnt != len_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            len_q       <= '0;
            wb_q        <= '0;
            xb_q        <= '0;
            prev_v      <= 1'b0;
            inst_w      <= 2'b00;
            sram_cen    <= 1'b1;
            sram_addr   <= '0;
            mode_select <= 1'b0;
            out_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state    <= nstate;
            cnt      <= ncnt;
            prev_v   <= array_valid[col-1];
            inst_w   <= {state == EXEC, state == LOAD};
            sram_cen <= !rd;
            busy     <= nstate != IDLE;
            done     <= nstate == FIN;
            err      <= timeout;
            if (rd) sram_addr <= naddr;
            if (accept) begin
                mode_select <= mode;
                len_q       <= exec_len;
                wb_q        <= w_base;
                xb_q        <= x_base;
                out_cnt     <= '0;
            end else if (inc) begin
                out_cnt <= out_cnt + len_bw'(1);
            end
        end
    end
endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
Sequencer for the 2D MAC array.
- Runs one tile per `start`: kernel load from weight SRAM, a settle gap, streaming of `exec_len` activation vectors, then a drain until all output vectors are seen.
- Drives the array's `inst_w` and `mode_select`, and the shared SRAM read port.
- Counts array output `valid` pulses and reports `done` or a timeout `err` to the top-level core.

Parameters:
- `row`, 8, array rows (input lanes); also the settle-gap length in cycles.
- `col`, 8, array columns; also the number of weight vectors loaded per tile.
- `len_bw`, 8, width of `exec_len` and `out_cnt`.
- `addr_bw`, 11, SRAM address width.

Ports:
- `clk`  input  1  single clock; all logic is on its rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `start`  input  1  tile start request, sampled only in IDLE.
- `mode`  input  1  array mode; latched into `mode_select` on an accepted start.
- `exec_len`  input  len_bw  number of activation vectors; latched on an accepted start.
- `w_base`  input  addr_bw  weight SRAM base address; latched on an accepted start.
- `x_base`  input  addr_bw  activation SRAM base address; latched on an accepted start.
- `sram_cen`  output  1  SRAM chip enable, active low, read-only use.
- `sram_addr`  output  addr_bw  SRAM read address.
- `inst_w`  output  2  array instruction: bit1 = execute, bit0 = kernel load.
- `mode_select`  output  1  array mode.
- `array_valid`  input  col  per-column valid from the bottom array row.
- `out_cnt`  output  len_bw  number of output vectors received this tile.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse on successful completion.
- `err`  output  1  one-cycle pulse on drain timeout.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at an edge, from any state, mid-tile included):
  - next cycle state = IDLE;
  - `inst_w`=00, `sram_cen`=1, `sram_addr`=0, `mode_select`=0;
  - `busy`=0, `done`=0, `err`=0, `out_cnt`=0; all counters = 0.
- SRAM read latency is 1 cycle. `inst_w` lags each read by exactly one cycle so that it aligns with the returned data.
- States: IDLE, LOAD, GAP, EXEC, DRAIN, FIN.
- IDLE:
  - Leaves IDLE only when `start`==1 and `exec_len`!=0; goes to LOAD and latches `mode`, `exec_len`, `w_base`, `x_base`.
  - `start` with `exec_len`==0 is ignored.
  - `out_cnt` clears on an accepted start.
- LOAD, `col` cycles, counter k = 0..col-1:
  - `sram_cen`=0, `sram_addr`=`w_base`+k (mod 2^addr_bw);
  - `inst_w`=01 in the following cycle.
- GAP, `row` cycles:
  - `sram_cen`=1;
  - `inst_w`=00, except the lagged final load cycle.
- EXEC, `exec_len` cycles, k = 0..exec_len-1:
  - `sram_cen`=0, `sram_addr`=`x_base`+k (mod 2^addr_bw), wrapping;
  - `inst_w`=10 one cycle later.
- DRAIN:
  - `sram_cen`=1; `inst_w`=00 after the last lagged exec cycle.
  - A drain timer counts from 0; goes to FIN when `out_cnt`==`exec_len`.
  - If the timer reaches 4*(row+col)-1 first: pulse `err`, go to IDLE.
- Output counting, in EXEC and DRAIN only:
  - `out_cnt` increments on each 0→1 rising edge of `array_valid[col-1]` (the last, most-skewed column).
  - Saturates at `exec_len`.
  - Valid edges seen in other states are ignored.
- FIN: `done`=1 for one cycle, then IDLE. `out_cnt` holds its value until the next accepted start.
- `mode_select` is held from the accepted start until the next accepted start.
- `start` while `busy` is ignored, with no queuing.

Test Plan:
- Basic tile (row=col=8):
  - Stimulus: `start` at cycle 0 with `exec_len`=4, `w_base`=0x010, `x_base`=0x100.
  - Required: `sram_cen` low cycles 1–8 with addr 0x010–0x017; `inst_w`=01 cycles 2–9; `sram_cen` high cycles 9–16; reads 0x100–0x103 in cycles 17–20; `inst_w`=10 cycles 18–21.
  - Then stub 4 `array_valid[7]` pulses → `out_cnt`=4, `done` pulses once, `busy` falls.
- `exec_len`=0 with `start`=1 → stays IDLE; `busy`=0, `sram_cen`=1 for 20 cycles.
- `start` pulsed during EXEC with different bases → ignored; the address sequence is unchanged and `mode_select` keeps its latched value.
- Reset low at cycle 18 of the basic tile → next cycle state IDLE, `inst_w`=00, `sram_cen`=1, `out_cnt`=0; a fresh start then replays the full basic sequence.
- Drain timeout:
  - Stimulus: only 3 of 4 valid pulses supplied.
  - Required: `err` pulses exactly 63 cycles after DRAIN entry; `done` never asserts; `out_cnt`=3.
- Address wrap: `x_base`=0x7FE, `exec_len`=4 → exec reads 0x7FE, 0x7FF, 0x000, 0x001.
